// File: rtl/clkmult.sv
// clkmult: clock multiplier for the eurorack-pmod sample-rate core set.
// Measures the period of a gate on sample_in0 with Schmitt thresholds and
// produces x2, x4 and x8 gate trains on sample_out1..3. The trains are
// phase-locked to each accepted rising edge.
// Optional macro CLKMULT_LOCK_OUT_EN: when defined, sample_out0 becomes a
// registered lock indicator (gate-high while running). When undefined,
// sample_out0 mirrors sample_in0 combinationally.
module clkmult #(
  parameter int W_PERIOD      = 16,
  parameter int MAX_PERIOD    = 48000,
  parameter int MIN_PERIOD    = 16,
  parameter int SCHMITT_HI_MV = 2000,
  parameter int SCHMITT_LO_MV = 500,
  parameter int OUT_HI_MV     = 5000
) (
  input  logic               sample_clk,
  input  logic               rst,
  input  logic signed [15:0] sample_in0,
  input  logic signed [15:0] sample_in1,
  input  logic signed [15:0] sample_in2,
  input  logic signed [15:0] sample_in3,
  output logic signed [15:0] sample_out0,
  output logic signed [15:0] sample_out1,
  output logic signed [15:0] sample_out2,
  output logic signed [15:0] sample_out3
);

  // Codes are millivolts with two fractional bits.
  localparam logic signed [15:0] HI     = 16'(SCHMITT_HI_MV * 4);
  localparam logic signed [15:0] LO     = 16'(SCHMITT_LO_MV * 4);
  localparam logic signed [15:0] OUT_HI = 16'(OUT_HI_MV * 4);
  localparam logic [W_PERIOD-1:0] MAX_CNT = W_PERIOD'(MAX_PERIOD);
  localparam logic [W_PERIOD-1:0] MIN_CNT = W_PERIOD'(MIN_PERIOD);
  localparam logic [W_PERIOD-1:0] ONE     = W_PERIOD'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic                last_hi_reg, last_hi_next;
  logic [W_PERIOD-1:0] cnt_reg, cnt_next;
  logic [W_PERIOD-1:0] period_reg, period_next;
  logic                rise, accept, timeout, resync;
  logic [2:0]          gate;

  // Inputs 1..3 carry no function in this block.
  logic unused_inputs;
  assign unused_inputs = ^{sample_in1, sample_in2, sample_in3};

  // A rise during IDLE always starts a measurement; later rises must be far
  // enough from the previous one to count, otherwise they are glitches.
  assign rise    = (sample_in0 > HI) && !last_hi_reg;
  assign accept  = rise && ((state_reg == IDLE) || (cnt_reg >= MIN_CNT));
  assign timeout = (cnt_reg >= MAX_CNT);

  // Next-state logic: Schmitt trigger, period counter and lock FSM.
  always_comb begin
    state_next   = state_reg;
    last_hi_next = last_hi_reg;
    cnt_next     = cnt_reg;
    period_next  = period_reg;
    resync       = 1'b0;

    if (rise) begin
      last_hi_next = 1'b1;
    end else if ((sample_in0 < LO) && last_hi_reg) begin
      last_hi_next = 1'b0;
    end

    if (accept) begin
      cnt_next = ONE;
    end else if (cnt_reg < MAX_CNT) begin
      cnt_next = cnt_reg + ONE;
    end

    // An accepted rise always wins over a timeout on the same cycle.
    case (state_reg)
      IDLE: begin
        if (accept) state_next = MEASURE;
      end
      MEASURE: begin
        if (accept) begin
          if (timeout) begin
            // Interval overflowed: treat this edge as a fresh first edge.
            state_next = MEASURE;
          end else begin
            state_next  = RUN;
            period_next = cnt_reg;
            resync      = 1'b1;
          end
        end else if (timeout) begin
          state_next  = IDLE;
          period_next = '0;
        end
      end
      RUN: begin
        if (accept) begin
          period_next = cnt_reg;
          resync      = 1'b1;
        end else if (timeout) begin
          state_next  = IDLE;
          period_next = '0;
        end
      end
      default: begin
        state_next  = IDLE;
        period_next = '0;
      end
    endcase
  end

  // State register for the Schmitt trigger, counter and FSM.
  always_ff @(posedge sample_clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      last_hi_reg <= 1'b0;
      cnt_reg     <= '0;
      period_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      last_hi_reg <= last_hi_next;
      cnt_reg     <= cnt_next;
      period_reg  <= period_next;
    end
  end

  // One generator per multiple: gen k emits 2^k pulses per input period.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gen_mult
      localparam int         K      = gi + 1;
      localparam logic [3:0] PC_MAX = 4'(1 << K);

      logic [W_PERIOD-1:0] ph_reg, ph_next, sub_len;
      logic [3:0]          pc_reg, pc_next;
      logic                gate_reg, gate_next;

      // Phase/pulse counting; once all pulses are emitted the phase freezes
      // so the floor remainder of the period never yields an extra pulse.
      always_comb begin
        sub_len = period_next >> K;
        ph_next = ph_reg;
        pc_next = pc_reg;
        if (resync || (state_next != RUN)) begin
          ph_next = '0;
          pc_next = '0;
        end else if (pc_reg < PC_MAX) begin
          if ((ph_reg + ONE) >= sub_len) begin
            ph_next = '0;
            pc_next = pc_reg + 4'd1;
          end else begin
            ph_next = ph_reg + ONE;
          end
        end
        gate_next = (state_next == RUN) && (pc_next < PC_MAX) &&
                    (ph_next < (sub_len >> 1));
      end

      // Registered phase, pulse count and gate level.
      always_ff @(posedge sample_clk) begin
        if (rst) begin
          ph_reg   <= '0;
          pc_reg   <= '0;
          gate_reg <= 1'b0;
        end else begin
          ph_reg   <= ph_next;
          pc_reg   <= pc_next;
          gate_reg <= gate_next;
        end
      end

      assign gate[gi] = gate_reg;
    end
  endgenerate

  assign sample_out1 = gate[0] ? OUT_HI : 16'sd0;
  assign sample_out2 = gate[1] ? OUT_HI : 16'sd0;
  assign sample_out3 = gate[2] ? OUT_HI : 16'sd0;

`ifdef CLKMULT_LOCK_OUT_EN
  logic lock_reg;

  // Lock indicator aligned with the cycles in which the FSM is in RUN.
  always_ff @(posedge sample_clk) begin
    if (rst) lock_reg <= 1'b0;
    else     lock_reg <= (state_next == RUN);
  end

  assign sample_out0 = lock_reg ? OUT_HI : 16'sd0;
`else
  assign sample_out0 = sample_in0;
`endif

endmodule

// File: tb/tb_clkmult.sv
// tb_clkmult: scenario tests for the clock multiplier; every step pushes the
// expected gate levels to a scoreboard queue and pops them once the DUT has
// registered that step.
module tb_clkmult;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] in0 = 16'sd0;
  logic signed [15:0] in1 = 16'sd123;
  logic signed [15:0] in2 = -16'sd77;
  logic signed [15:0] in3 = 16'sd9000;
  logic signed [15:0] sample_out0, sample_out1, sample_out2, sample_out3;

  int passed = 0;
  int total  = 0;
  logic [47:0] sb_q[$];

  always #5 clk = ~clk;

  clkmult #(.MAX_PERIOD(1000)) dut (
    .sample_clk (clk),
    .rst        (rst),
    .sample_in0 (in0),
    .sample_in1 (in1),
    .sample_in2 (in2),
    .sample_in3 (in3),
    .sample_out0(sample_out0),
    .sample_out1(sample_out1),
    .sample_out2(sample_out2),
    .sample_out3(sample_out3)
  );

  // Drive one sample away from the edge, then settle just after the edge.
  task automatic tick(input logic signed [15:0] v);
    @(negedge clk);
    in0 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(16'sd0);
    tick(16'sd0);
    rst = 1'b0;
  endtask

  // Expected gate for offset j after the locking edge: n pulses of sub cycles,
  // high for the first floor(sub/2) cycles of each.
  function automatic logic [15:0] g(input int j, input int sub, input int n);
    if (sub > 0 && (j / sub) < n && (j % sub) < (sub / 2)) return 16'd20000;
    return 16'd0;
  endfunction

  function automatic logic [47:0] exp_gates(input int j, input int period);
    return {g(j, period >> 1, 2), g(j, period >> 2, 4), g(j, period >> 3, 8)};
  endfunction

  function automatic logic signed [15:0] lvl(input bit hi);
    return hi ? 16'sd16000 : 16'sd0;
  endfunction

  task automatic test_reset();
    logic [47:0] e, act;
    logic signed [15:0] e0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(48'd0);
      tick(16'sd16000);
      act = {sample_out1, sample_out2, sample_out3};
      e = sb_q.pop_front();
      total++;
      if (act !== e) $display("FAIL reset_gates cyc %0d: got %h expected %h", i, act, e);
      else passed++;
`ifdef CLKMULT_LOCK_OUT_EN
      e0 = 16'sd0;
`else
      e0 = 16'sd16000;
`endif
      total++;
      if (sample_out0 !== e0) $display("FAIL reset_out0 cyc %0d: got %0d expected %0d", i, sample_out0, e0);
      else passed++;
    end
    rst = 1'b0;
    tick(16'sd0);
    tick(-16'sd1234);
`ifdef CLKMULT_LOCK_OUT_EN
    e0 = 16'sd0;
`else
    e0 = -16'sd1234;
`endif
    total++;
    if (sample_out0 !== e0) $display("FAIL out0_mirror: got %0d expected %0d", sample_out0, e0);
    else passed++;
    tick(16'sd0);
  endtask

  task automatic test_lock();
    int c1 = 0, c2 = 0, c3 = 0;
    logic [2:0] prev = 3'b000;
    do_reset();
    for (int s = 0; s < 256; s++) begin
      logic [47:0] e, act;
      e = (s < 64) ? 48'd0 : exp_gates((s - 64) % 64, 64);
      sb_q.push_back(e);
      tick(lvl((s % 64) < 32));
      act = {sample_out1, sample_out2, sample_out3};
      e = sb_q.pop_front();
      total++;
      if (act !== e) $display("FAIL lock step %0d: got %h expected %h", s, act, e);
      else passed++;
      if (s >= 192) begin
        if (sample_out1 != 0 && !prev[2]) c1++;
        if (sample_out2 != 0 && !prev[1]) c2++;
        if (sample_out3 != 0 && !prev[0]) c3++;
      end
      prev = {sample_out1 != 0, sample_out2 != 0, sample_out3 != 0};
    end
    total++;
    if (c1 != 2) $display("FAIL lock_pulses_x2: got %0d expected 2", c1); else passed++;
    total++;
    if (c2 != 4) $display("FAIL lock_pulses_x4: got %0d expected 4", c2); else passed++;
    total++;
    if (c3 != 8) $display("FAIL lock_pulses_x8: got %0d expected 8", c3); else passed++;
  endtask

  task automatic test_schmitt();
    do_reset();
    for (int s = 0; s < 192; s++) begin
      logic [47:0] e, act;
      logic signed [15:0] v;
      v = lvl((s % 64) < 32);
      if (s == 69 || s == 70 || s == 84 || s == 85) v = 16'sd4000;
      if (s < 64)       e = 48'd0;
      else if (s < 128) e = exp_gates(s - 64, 64);
      else              e = exp_gates(s - 128, 64);
      sb_q.push_back(e);
      tick(v);
      act = {sample_out1, sample_out2, sample_out3};
      e = sb_q.pop_front();
      total++;
      if (act !== e) $display("FAIL schmitt step %0d: got %h expected %h", s, act, e);
      else passed++;
    end
  endtask

  task automatic test_remainder();
    do_reset();
    for (int s = 0; s < 210; s++) begin
      logic [47:0] e, act;
      e = (s < 70) ? 48'd0 : exp_gates((s - 70) % 70, 70);
      sb_q.push_back(e);
      tick(lvl((s % 70) < 35));
      act = {sample_out1, sample_out2, sample_out3};
      e = sb_q.pop_front();
      total++;
      if (act !== e) $display("FAIL remainder step %0d: got %h expected %h", s, act, e);
      else passed++;
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int s = 0; s < 144; s++) begin
      logic [47:0] e, act;
      bit hi;
      hi = (s < 32) || (s >= 64 && s < 68) || (s >= 72 && s < 76) ||
           (s >= 104 && s < 108);
      if (s < 64)       e = 48'd0;
      else if (s < 104) e = exp_gates(s - 64, 64);
      else              e = exp_gates(s - 104, 40);
      sb_q.push_back(e);
      tick(lvl(hi));
      act = {sample_out1, sample_out2, sample_out3};
      e = sb_q.pop_front();
      total++;
      if (act !== e) $display("FAIL glitch step %0d: got %h expected %h", s, act, e);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    for (int s = 0; s < 185; s++) begin
      logic [47:0] e, act;
      if (s < 64)       e = 48'd0;
      else if (s < 70)  e = exp_gates(s - 64, 64);
      else if (s < 128) e = 48'd0;
      else              e = exp_gates(s - 128, 57);
      sb_q.push_back(e);
      rst = (s == 70);
      tick(lvl((s % 64) < 32));
      rst = 1'b0;
      act = {sample_out1, sample_out2, sample_out3};
      e = sb_q.pop_front();
      total++;
      if (act !== e) $display("FAIL reset_mid_run step %0d: got %h expected %h", s, act, e);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int s = 0; s < 2193; s++) begin
      logic [47:0] e, act;
      bit hi;
      hi = (s < 32) || (s >= 64 && s < 96) || (s >= 1064 && s < 1096) ||
           (s >= 2065 && s < 2097) || (s >= 2129 && s < 2161);
      if (s < 64)        e = 48'd0;
      else if (s < 1064) e = exp_gates(s - 64, 64);
      else if (s < 2064) e = exp_gates(s - 1064, 1000);
      else if (s < 2129) e = 48'd0;
      else               e = exp_gates(s - 2129, 64);
      sb_q.push_back(e);
      tick(lvl(hi));
      act = {sample_out1, sample_out2, sample_out3};
      e = sb_q.pop_front();
      total++;
      if (act !== e) $display("FAIL timeout step %0d: got %h expected %h", s, act, e);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_schmitt();
    test_remainder();
    test_glitch();
    test_reset_mid_run();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
